// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with grant locking: a grant stays with its holder until release,
// request drop, or HOLD_MAX consecutive cycles; the search restarts one past the last holder.
module rr_grant_arbiter #(
   parameter int ARB_NUM  = 4,
   parameter int HOLD_MAX = 16,
   parameter int IDX_W    = (ARB_NUM > 1) ? $clog2(ARB_NUM) : 1
) (
   input  logic               iClk,
   input  logic               iRst_n,
   input  logic [ARB_NUM-1:0] iReq,
   input  logic               iRelease,
   output logic [ARB_NUM-1:0] oGnt,
   output logic               oGntValid,
   output logic [IDX_W-1:0]   oGntIdx,
   output logic               oTimeout
);

   localparam int CNT_W = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

   typedef enum logic {IDLE, GRANT} state_e;

   state_e             state_q;
   logic [ARB_NUM-1:0] gnt_q;
   logic               gnt_valid_q;
   logic [IDX_W-1:0]   gnt_idx_q;
   logic               timeout_q;
   logic [IDX_W-1:0]   ptr_q;
   logic [CNT_W-1:0]   hold_cnt_q;

   logic [IDX_W-1:0]   ptr_after_h_d;
   logic [IDX_W-1:0]   search_ptr_d;
   logic               at_limit_d;
   logic               rel_d;
   logic               win_valid_d;
   logic [IDX_W-1:0]   win_idx_d;
   logic [ARB_NUM-1:0] win_gnt_d;

   // First requester at or after start, wrapping modulo ARB_NUM; MSB flags a hit.
   function automatic logic [IDX_W:0] pick(input logic [ARB_NUM-1:0] req,
                                           input logic [IDX_W-1:0]   start);
      logic             found;
      logic [IDX_W-1:0] idx;
      int               pos;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < ARB_NUM; k++) begin
         pos = (int'(start) + k) % ARB_NUM;
         if (!found && req[pos]) begin
            found = 1'b1;
            idx   = IDX_W'(pos);
         end
      end
      return {found, idx};
   endfunction

   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      ptr_after_h_d = (gnt_idx_q == IDX_W'(ARB_NUM - 1)) ? '0 : gnt_idx_q + 1'b1;
      at_limit_d    = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LIM);
      rel_d         = iRelease | ~iReq[gnt_idx_q] | at_limit_d;
      search_ptr_d  = (state_q == GRANT) ? ptr_after_h_d : ptr_q;
      {win_valid_d, win_idx_d} = pick(iReq, search_ptr_d);
      win_gnt_d            = '0;
      win_gnt_d[win_idx_d] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         gnt_idx_q   <= '0;
         timeout_q   <= 1'b0;
         ptr_q       <= '0;
         hold_cnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               timeout_q <= 1'b0;
               if (win_valid_d) begin
                  state_q     <= GRANT;
                  gnt_q       <= win_gnt_d;
                  gnt_valid_q <= 1'b1;
                  gnt_idx_q   <= win_idx_d;
                  hold_cnt_q  <= CNT_W'(1);
               end
            end
            GRANT: begin
               if (!rel_d) begin
                  timeout_q <= 1'b0;
                  if (hold_cnt_q != '1) hold_cnt_q <= hold_cnt_q + 1'b1;
               end else begin
                  ptr_q     <= ptr_after_h_d;
                  // Pulse only when the limit alone forced the revoke.
                  timeout_q <= at_limit_d & ~iRelease & iReq[gnt_idx_q];
                  if (win_valid_d) begin
                     gnt_q      <= win_gnt_d;
                     gnt_idx_q  <= win_idx_d;
                     hold_cnt_q <= CNT_W'(1);
                  end else begin
                     state_q     <= IDLE;
                     gnt_q       <= '0;
                     gnt_valid_q <= 1'b0;
                     gnt_idx_q   <= '0;
                     hold_cnt_q  <= '0;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign oGnt      = gnt_q;
   assign oGntValid = gnt_valid_q;
   assign oGntIdx   = gnt_idx_q;
   assign oTimeout  = timeout_q;

endmodule
